// File: rtl/dla_kpe_acc_expand_pkg.sv
// Shared types and constants for the KPE accumulator-expand path.
package dla_kpe_acc_expand_pkg;

    typedef enum logic {
        PREC_IFMAP_8  = 1'b0,
        PREC_IFMAP_16 = 1'b1
    } precision_ifmap_e;

    localparam int KPE_SHIFT_MAX_16 = 12;
    localparam int KPE_SHIFT_MAX_8  = 8;
    localparam int KPE_ACC_W        = 32;
    localparam int KPE_RS_W         = 24;

endpackage

// File: rtl/dla_kpe_acc_expand_shl.sv
// One lane of the expand path: sign-extend, arithmetic left shift, saturate to OUT_W.
module dla_kpe_shl_sat #(
    parameter int IN_W  = 24,
    parameter int OUT_W = 32
) (
    input  logic signed [IN_W-1:0]  data,
    input  logic        [3:0]       shift,
    output logic signed [OUT_W-1:0] result,
    output logic                    sat
);

    // Headroom for the largest 4-bit shift, so no bits are lost before saturating.
    localparam int EXT_W = IN_W + 16;

    function automatic logic [OUT_W:0] sat_to_out(input logic signed [EXT_W-1:0] v);
        logic [EXT_W-OUT_W:0] top;
        top = v[EXT_W-1:OUT_W-1];
        if (&top || ~|top)
            return {1'b0, v[OUT_W-1:0]};
        else if (v[EXT_W-1])
            return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
        else
            return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
    endfunction

    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] shl;

    always_comb begin
        ext           = {{(EXT_W-IN_W){data[IN_W-1]}}, data};
        shl           = ext <<< shift;
        {sat, result} = sat_to_out(shl);
    end

endmodule

// File: rtl/dla_kpe_acc_expand.sv
// Rebuilds accumulator-domain partial sums from requantized KPE results:
// two-stage valid/ready pipeline with saturation statistics.
module dla_kpe_acc_expand
    import dla_kpe_acc_expand_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [23:0]            in_data,
    input  logic [3:0]             in_shift,
    input  precision_ifmap_e       in_precision,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_data,
    output logic [1:0]             out_sat,
    output logic                   sat_sticky,
    output logic [CNT_W-1:0]       sat_cnt,
    output logic                   shift_err,
    input  logic                   stat_clr
);

    logic                    vld_p1, vld_p2;
    logic [KPE_RS_W-1:0]     data_p1;
    logic [3:0]              shift_p1;
    precision_ifmap_e        prec_p1;
    logic                    s1_en, s2_en, accept, xfer;
    logic                    shift_bad;
    logic [3:0]              shift_eff;

    logic signed [KPE_ACC_W-1:0]   wide_res;
    logic signed [KPE_ACC_W/2-1:0] hi_res, lo_res;
    logic                          wide_sat, hi_sat, lo_sat;
    logic [KPE_ACC_W-1:0]          data_d;
    logic [1:0]                    sat_d;

    assign s2_en     = !vld_p2 || out_ready;
    assign s1_en     = !vld_p1 || s2_en;
    assign in_ready  = s1_en;
    assign accept    = in_valid && in_ready;
    assign out_valid = vld_p2;
    assign xfer      = vld_p2 && out_ready;

    // Out-of-range shifts are clamped to the mode maximum; the beat still flows.
    always_comb begin
        shift_bad = 1'b0;
        shift_eff = in_shift;
        if (in_precision == PREC_IFMAP_16) begin
            shift_bad = in_shift > 4'(KPE_SHIFT_MAX_16);
            if (shift_bad) shift_eff = 4'(KPE_SHIFT_MAX_16);
        end else begin
            shift_bad = in_shift > 4'(KPE_SHIFT_MAX_8);
            if (shift_bad) shift_eff = 4'(KPE_SHIFT_MAX_8);
        end
    end

    // Stage 1: capture the accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vld_p1 <= 1'b0;
        else if (s1_en)
            vld_p1 <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            data_p1  <= in_data;
            shift_p1 <= shift_eff;
            prec_p1  <= in_precision;
        end
    end

    dla_kpe_shl_sat #(.IN_W(KPE_RS_W), .OUT_W(KPE_ACC_W)) u_shl_wide (
        .data(data_p1), .shift(shift_p1), .result(wide_res), .sat(wide_sat)
    );
    dla_kpe_shl_sat #(.IN_W(KPE_RS_W/2), .OUT_W(KPE_ACC_W/2)) u_shl_hi (
        .data(data_p1[KPE_RS_W-1:KPE_RS_W/2]), .shift(shift_p1), .result(hi_res), .sat(hi_sat)
    );
    dla_kpe_shl_sat #(.IN_W(KPE_RS_W/2), .OUT_W(KPE_ACC_W/2)) u_shl_lo (
        .data(data_p1[KPE_RS_W/2-1:0]), .shift(shift_p1), .result(lo_res), .sat(lo_sat)
    );

    always_comb begin
        data_d = wide_res;
        sat_d  = {1'b0, wide_sat};
        if (prec_p1 == PREC_IFMAP_8) begin
            data_d = {hi_res, lo_res};
            sat_d  = {hi_sat, lo_sat};
        end
    end

    // Stage 2: registered result, held while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2   <= 1'b0;
            out_data <= '0;
            out_sat  <= '0;
        end else if (s2_en) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                out_data <= data_d;
                out_sat  <= sat_d;
            end
        end
    end

    // Statistics: clear takes priority over any simultaneous set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_sticky <= 1'b0;
            sat_cnt    <= '0;
            shift_err  <= 1'b0;
        end else if (stat_clr) begin
            sat_sticky <= 1'b0;
            sat_cnt    <= '0;
            shift_err  <= 1'b0;
        end else begin
            if (xfer && |out_sat) begin
                sat_sticky <= 1'b1;
                if (!(&sat_cnt)) sat_cnt <= sat_cnt + 1'b1;
            end
            if (accept && shift_bad) shift_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dla_kpe_acc_expand.sv
// Directed-vector bench for dla_kpe_acc_expand with hand-computed expectations.
module tb_dla_kpe_acc_expand;
    import dla_kpe_acc_expand_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [23:0]      in_data;
    logic [3:0]       in_shift;
    precision_ifmap_e in_precision;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [1:0]       out_sat;
    logic             sat_sticky;
    logic [15:0]      sat_cnt;
    logic             shift_err;
    logic             stat_clr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dla_kpe_acc_expand #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shift(in_shift), .in_precision(in_precision),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .sat_sticky(sat_sticky), .sat_cnt(sat_cnt),
        .shift_err(shift_err), .stat_clr(stat_clr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [23:0] d, input logic [3:0] s, input precision_ifmap_e p);
        in_valid     = 1'b1;
        in_data      = d;
        in_shift     = s;
        in_precision = p;
    endtask

    logic [23:0] bp_data [4] = '{24'h000011, 24'h000022, 24'hFFFFF0, 24'h000044};
    logic [31:0] bp_exp  [4] = '{32'h00000110, 32'h00000220, 32'hFFFFFF00, 32'h00000440};
    logic        bp_pat  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int tx;
        int rx;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shift = '0;
        in_precision = PREC_IFMAP_16; out_ready = 1'b0; stat_clr = 1'b0;
        repeat (3) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_sat_sticky", sat_sticky, 0);
        check("rst_sat_cnt", sat_cnt, 0);
        check("rst_shift_err", shift_err, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        tick();

        // 16-bit basic shift, latency
        out_ready = 1'b1;
        present(24'h000123, 4'd4, PREC_IFMAP_16);
        tick(); in_valid = 1'b0;
        check("t1_lat_early", out_valid, 0);
        tick();
        check("t1_valid", out_valid, 1);
        check("t1_data", out_data, 32'h00001230);
        check("t1_sat", out_sat, 2'b00);
        tick();
        check("t1_drain", out_valid, 0);

        // 16-bit positive saturation
        present(24'h7FFFFF, 4'd12, PREC_IFMAP_16);
        tick(); in_valid = 1'b0;
        tick();
        check("t2_data", out_data, 32'h7FFFFFFF);
        check("t2_sat", out_sat, 2'b01);
        tick();
        check("t2_cnt", sat_cnt, 1);
        check("t2_sticky", sat_sticky, 1);

        // 8-bit lanes, back-to-back with mode/shift change
        present(24'h80007F, 4'd8, PREC_IFMAP_8);
        tick();
        present(24'hFFF001, 4'd1, PREC_IFMAP_8);
        tick(); in_valid = 1'b0;
        check("t3a_data", out_data, 32'h80007F00);
        check("t3a_sat", out_sat, 2'b10);
        tick();
        check("t3b_valid", out_valid, 1);
        check("t3b_data", out_data, 32'hFFFE0002);
        check("t3b_sat", out_sat, 2'b00);
        check("t3_cnt", sat_cnt, 2);
        tick();

        // Backpressure stream
        tx = 0; rx = 0;
        for (int c = 0; c < 40 && rx < 4; c++) begin
            out_ready = bp_pat[c % 4];
            if (tx < 4) present(bp_data[tx], 4'd4, PREC_IFMAP_16);
            else in_valid = 1'b0;
            #1;
            check("bp_in_ready", in_ready, !((tx - rx) == 2 && !out_ready));
            if (out_valid && out_ready) begin
                check("bp_data", out_data, bp_exp[rx]);
                rx++;
            end
            if (in_valid && in_ready) tx++;
            tick();
        end
        in_valid = 1'b0;
        check("bp_rx_count", rx, 4);
        check("bp_no_extra", out_valid, 0);

        // Illegal shift in 8-bit mode clamps to 8
        out_ready = 1'b1;
        present(24'h001100, 4'd11, PREC_IFMAP_8);
        tick(); in_valid = 1'b0;
        check("t5_shift_err", shift_err, 1);
        tick();
        check("t5_data", out_data, 32'h01007FFF);
        check("t5_sat", out_sat, 2'b01);
        tick();
        present(24'h7FFFFF, 4'd12, PREC_IFMAP_16);
        tick(); in_valid = 1'b0;
        tick();
        check("t5_pre_cnt", sat_cnt, 3);
        check("t5_pre_sat", out_sat, 2'b01);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        check("t5_clr_cnt", sat_cnt, 0);
        check("t5_clr_sticky", sat_sticky, 0);
        check("t5_clr_shift_err", shift_err, 0);

        // Reset with both stages full
        out_ready = 1'b0;
        present(24'h000001, 4'd0, PREC_IFMAP_16);
        tick();
        present(24'h000002, 4'd0, PREC_IFMAP_16);
        tick(); in_valid = 1'b0;
        check("t6_full_in_ready", in_ready, 0);
        check("t6_full_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_in_ready", in_ready, 1);
        tick(); tick();
        rst = 1'b0;
        out_ready = 1'b1;
        check("t6_post_valid", out_valid, 0);
        check("t6_post_in_ready", in_ready, 1);
        present(24'hFFFFFF, 4'd3, PREC_IFMAP_16);
        tick(); in_valid = 1'b0;
        check("t6_lat_early", out_valid, 0);
        tick();
        check("t6_valid", out_valid, 1);
        check("t6_data", out_data, 32'hFFFFFFF8);
        tick();
        check("t6_no_ghost", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
